// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two requesters,
// with a registered operand stage, one ALU cycle and a response held until accepted.
module alu_arbiter #(
    parameter int W = 32
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         REQ_VALID_0,
    input  logic         REQ_VALID_1,
    output logic         REQ_READY_0,
    output logic         REQ_READY_1,
    input  logic [3:0]   REQ_CONTROL_0,
    input  logic [3:0]   REQ_CONTROL_1,
    input  logic [W-1:0] REQ_X_0,
    input  logic [W-1:0] REQ_X_1,
    input  logic [W-1:0] REQ_Y_0,
    input  logic [W-1:0] REQ_Y_1,
    output logic         RSP_VALID_0,
    output logic         RSP_VALID_1,
    input  logic         RSP_READY_0,
    input  logic         RSP_READY_1,
    output logic [W-1:0] RSP_RESULT,
    output logic         RSP_ZERO,
    output logic         RSP_ERR,
    output logic [W-1:0] ALU_X,
    output logic [W-1:0] ALU_Y,
    output logic [3:0]   ALU_CONTROL,
    input  logic [W-1:0] ALU_RESULTADO,
    input  logic         ALU_ZERO
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t state;
    logic last, owner, gnt, any, legal, shift, err;
    logic [3:0] ctrl_in, op_ctrl;
    logic [W-1:0] x_in, y_raw, y_in, op_x, op_y;
    assign any = REQ_VALID_0 | REQ_VALID_1;
    // on contention the requester that did not win last time gets the ALU
    assign gnt = (REQ_VALID_0 & REQ_VALID_1) ? ~last : REQ_VALID_1;
    assign REQ_READY_0 = !RESET && state == IDLE && REQ_VALID_0 && !gnt;
    assign REQ_READY_1 = !RESET && state == IDLE && REQ_VALID_1 && gnt;
    assign ctrl_in = gnt ? REQ_CONTROL_1 : REQ_CONTROL_0;
    assign x_in = gnt ? REQ_X_1 : REQ_X_0;
    assign y_raw = gnt ? REQ_Y_1 : REQ_Y_0;
    assign legal = ctrl_in inside {4'b0000, 4'b0111, 4'b0100, 4'b1100, 4'b0010, 4'b0001,
                                   4'b1001, 4'b0110, 4'b1000, 4'b1010, 4'b1110};
    assign shift = ctrl_in inside {4'b1000, 4'b1010, 4'b1110};
    assign y_in = shift ? {{(W-5){1'b0}}, y_raw[4:0]} : y_raw;
    assign RSP_VALID_0 = !RESET && state == RESP && !owner;
    assign RSP_VALID_1 = !RESET && state == RESP && owner;
    assign ALU_X = op_x;
    assign ALU_Y = op_y;
    assign ALU_CONTROL = op_ctrl;
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
            last <= 1'b1;
            owner <= 1'b0;
            op_ctrl <= '0;
            op_x <= '0;
            op_y <= '0;
            err <= 1'b0;
            RSP_RESULT <= '0;
            RSP_ZERO <= 1'b0;
            RSP_ERR <= 1'b0;
        end else begin
            case (state)
                IDLE: if (any) begin
                    state <= EXEC;
                    owner <= gnt;
                    last <= gnt;
                    op_ctrl <= ctrl_in;
                    op_x <= x_in;
                    op_y <= y_in;
                    err <= !legal;
                end
                EXEC: begin
                    state <= RESP;
                    RSP_RESULT <= err ? '0 : ALU_RESULTADO;
                    RSP_ZERO <= err | ALU_ZERO;
                    RSP_ERR <= err;
                end
                RESP: if (owner ? RSP_READY_1 : RSP_READY_0) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
    // a waiting requester must hold its payload until it is accepted
    a_hold_0: assert property (@(posedge CLK) disable iff (RESET)
        REQ_VALID_0 && !REQ_READY_0 |=> REQ_VALID_0 && $stable({REQ_CONTROL_0, REQ_X_0, REQ_Y_0}));
    a_hold_1: assert property (@(posedge CLK) disable iff (RESET)
        REQ_VALID_1 && !REQ_READY_1 |=> REQ_VALID_1 && $stable({REQ_CONTROL_1, REQ_X_1, REQ_Y_1}));
endmodule
